// File: rtl/usb_ctrl_out_pio.sv
// Avalon-MM output PIO for USB control lines. It has a data register, a set/clear
// alias, and a one-shot pulse engine that inverts masked bits for a programmable length.
module usb_ctrl_out_pio #(
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(4'h0)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int unsigned CW = 16;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] PULSE = 1'b1;

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_PLEN = 3'd1;
  localparam logic [2:0] A_TRIG = 3'd2;
  localparam logic [2:0] A_STAT = 3'd3;
  localparam logic [2:0] A_SET  = 3'd4;
  localparam logic [2:0] A_CLR  = 3'd5;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CW-1:0]    plen_q, plen_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovr_q, ovr_d;

  logic             wr_c;
  logic             trig_c;
  logic [WIDTH-1:0] wval_c;
  logic [31:0]      rd_c;
  logic             unused_wdata_hi;

  assign wr_c            = chipselect & ~write_n;
  assign trig_c          = wr_c && (address == A_TRIG);
  assign wval_c          = writedata[WIDTH-1:0];
  assign unused_wdata_hi = ^writedata[31:CW];

  // Next-state and register-update logic
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    plen_d  = plen_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;

    if (wr_c) begin
      case (address)
        A_DATA:  data_d = wval_c;
        A_PLEN:  plen_d = writedata[CW-1:0];
        A_STAT:  ovr_d  = 1'b0;
        A_SET:   data_d = data_q | wval_c;
        A_CLR:   data_d = data_q & ~wval_c;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (trig_c && (wval_c != '0)) begin
          mask_d  = wval_c;
          cnt_d   = (plen_q == '0) ? CW'(1) : plen_q;
          state_d = PULSE;
        end
      end
      PULSE: begin
        // A trigger while a pulse runs is dropped and flagged
        if (trig_c) ovr_d = 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          mask_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read mux, captured every cycle regardless of chipselect
  always_comb begin
    rd_c = '0;
    case (address)
      A_DATA:  rd_c = 32'(data_q);
      A_PLEN:  rd_c = 32'(plen_q);
      A_TRIG:  rd_c = 32'(mask_q);
      A_STAT:  rd_c = {30'd0, ovr_q, (state_q == PULSE)};
      default: rd_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      plen_q   <= '0;
      cnt_q    <= '0;
      ovr_q    <= 1'b0;
      readdata <= '0;
      out_port <= RESET_VALUE;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      plen_q   <= plen_d;
      cnt_q    <= cnt_d;
      ovr_q    <= ovr_d;
      readdata <= rd_c;
      out_port <= data_q ^ mask_q;
    end
  end

endmodule

// File: doc/usb_ctrl_out_pio.md
USB_CTRL_OUT_PIO -- requirements
Module: usb_ctrl_out_pio

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 4, which sets the number of output control lines.
REQ-002 The block SHALL have the parameter RESET_VALUE, default 4'h0, which sets the data register value after reset.
REQ-003 The block SHALL have the input port clk, 1 bit: the single clock, with all state on its rising edge.
REQ-004 The block SHALL have the input port reset_n, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have the input port address, 3 bits: Avalon-MM slave word address.
REQ-006 The block SHALL have the input port chipselect, 1 bit: slave select.
REQ-007 The block SHALL have the input port write_n, 1 bit: active-low write strobe, qualified by chipselect.
REQ-008 The block SHALL have the input port writedata, 32 bits: write data.
REQ-009 The block SHALL have the output port readdata, 32 bits: registered read data.
REQ-010 The block SHALL have the output port out_port, WIDTH bits: the control lines driven toward the USB device.

Function
REQ-011 A write SHALL occur in any cycle where chipselect=1 and write_n=0.
REQ-012 Only writedata[WIDTH-1:0] SHALL be used for the data and mask registers.
REQ-013 Address 0 SHALL be the data register (DATA), readable and writable.
REQ-014 Address 1 SHALL be the pulse length register (PLEN), 16 bits, readable and writable.
REQ-015 Address 2 SHALL be the pulse trigger: a write loads a mask (MASK); a read returns the active mask.
REQ-016 Address 3 SHALL be the status register: bit0=busy, bit1=overrun (sticky); a write of any value clears overrun.
REQ-017 Address 4 SHALL be outset: a write performs DATA <= DATA | writedata; a read returns 0.
REQ-018 Address 5 SHALL be outclear: a write performs DATA <= DATA & ~writedata; a read returns 0.
REQ-019 Addresses 6 and 7 SHALL read 0, and writes to them SHALL be ignored.
REQ-020 readdata SHALL be registered, presenting the value selected by the current address one cycle later, every cycle regardless of chipselect, with unused upper bits zero.
REQ-021 The FSM SHALL have two states: IDLE and PULSE.
REQ-022 In IDLE, a trigger write with a nonzero mask SHALL, on the next edge, load MASK, load the 16-bit counter with PLEN (with PLEN=0 treated as 1), and move the FSM to PULSE.
REQ-023 In IDLE, a trigger write with a zero mask SHALL be ignored.
REQ-024 In PULSE, the counter SHALL decrement by 1 each cycle; when the counter equals 1, the next edge SHALL return the FSM to IDLE and clear MASK to 0.
REQ-025 out_port SHALL be registered and equal DATA ^ MASK, lagging register updates by one cycle, so a pulse inverts the masked bits for exactly max(PLEN,1) cycles.
REQ-026 A trigger write in PULSE SHALL be ignored for the pulse and SHALL set overrun; the in-progress pulse SHALL be unaffected.
REQ-027 DATA writes (addresses 0, 4, 5) during PULSE SHALL take effect immediately, with out_port continuing to reflect the new DATA ^ MASK.
REQ-028 A PLEN write during PULSE SHALL affect only subsequent pulses.
REQ-029 busy SHALL be 1 exactly while the FSM is in PULSE.
REQ-030 The counter SHALL NOT wrap: PLEN=16'hFFFF SHALL give 65535 cycles.

Reset
REQ-031 On reset_n=0, asynchronously: DATA=RESET_VALUE, PLEN=0, MASK=0, counter=0, FSM=IDLE, overrun=0, readdata=0, out_port=RESET_VALUE.
REQ-032 Reset asserted during PULSE SHALL abort the pulse immediately, with no residual inversion after release.
REQ-033 After reset release, the block SHALL accept accesses on the first clock edge.

Verification
REQ-034 Reset with RESET_VALUE=4'h0, then write DATA=4'hA and read address 0 -> out_port=4'hA one cycle after the write; readdata=32'hA one cycle after the read address is presented.
REQ-035 Set PLEN=3 and DATA=4'h0, then write trigger 4'h1 -> out_port=4'h1 for exactly 3 cycles, busy=1 for those 3 cycles, then out_port=4'h0 and busy=0.
REQ-036 Set PLEN=0 and write trigger 4'h2 -> a 1-cycle pulse on out_port[1].
REQ-037 During a 10-cycle pulse, write trigger 4'h4 and outset 4'h8 -> out_port=4'h9 during the pulse, the pulse length stays 10, out_port=4'h8 afterward, and status=2'b10; a subsequent write to status clears it to 0.
REQ-038 Assert reset_n mid-pulse -> out_port=RESET_VALUE immediately and busy=0 after release.
REQ-039 Write outclear 4'hF while DATA=4'hF, then read addresses 4 and 6 -> out_port=4'h0 and both reads return 0.
